// File: rtl/gpr_file.sv
// General-purpose register file: pipeline write port, two bypassed combinational
// read ports, and a request/acknowledge debug port sharing the single write port.
module gpr_file #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr1_i,
  output logic [DW-1:0] rdata1_o,
  input  logic [AW-1:0] raddr2_i,
  output logic [DW-1:0] rdata2_o,
  input  logic          dbg_req_i,
  input  logic          dbg_we_i,
  input  logic [AW-1:0] dbg_addr_i,
  input  logic [DW-1:0] dbg_wdata_i,
  output logic          dbg_busy_o,
  output logic          dbg_ack_o,
  output logic [DW-1:0] dbg_rdata_o
);

  localparam int DEPTH = 2 ** AW;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  // Debug handshake: dbg_req_i is sampled only in IDLE; the request is then
  // busy until dbg_ack_o pulses for one cycle, after which the port is idle.
  logic [1:0]    state_q, state_d;
  logic          cap_we_q;
  logic [AW-1:0] cap_addr_q;
  logic [DW-1:0] cap_wdata_q;
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
  logic [DW-1:0] regs_q [DEPTH];

  logic          dbg_commit_wr;
  logic          dbg_commit_rd;
  logic [DW-1:0] byp_dbg;

  // A pending debug write may only use the write port when the pipeline does not.
  assign dbg_commit_wr = (state_q == ST_PEND) && cap_we_q && !we_i;
  assign dbg_commit_rd = (state_q == ST_PEND) && !cap_we_q;

  function automatic logic [DW-1:0] read_byp(
    input logic [AW-1:0] a,
    input logic [DW-1:0] stored,
    input logic          pwe,
    input logic [AW-1:0] pwaddr,
    input logic [DW-1:0] pwdata,
    input logic          dwr,
    input logic [AW-1:0] dwaddr,
    input logic [DW-1:0] dwdata
  );
    logic [DW-1:0] r;
    r = stored;
    if (a == '0)                   r = '0;
    else if (pwe && pwaddr == a)   r = pwdata;
    else if (dwr && dwaddr == a)   r = dwdata;
    return r;
  endfunction

  always_comb begin
    rdata1_o = read_byp(raddr1_i, regs_q[raddr1_i], we_i, waddr_i, wdata_i,
                        dbg_commit_wr, cap_addr_q, cap_wdata_q);
    rdata2_o = read_byp(raddr2_i, regs_q[raddr2_i], we_i, waddr_i, wdata_i,
                        dbg_commit_wr, cap_addr_q, cap_wdata_q);
    byp_dbg  = read_byp(cap_addr_q, regs_q[cap_addr_q], we_i, waddr_i, wdata_i,
                        dbg_commit_wr, cap_addr_q, cap_wdata_q);
  end

  always_comb begin
    state_d     = state_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      ST_IDLE: if (dbg_req_i) state_d = ST_PEND;
      ST_PEND: begin
        if (dbg_commit_rd) begin
          dbg_rdata_d = byp_dbg;
          state_d     = ST_ACK;
        end else if (dbg_commit_wr) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cap_we_q    <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      dbg_rdata_q <= dbg_rdata_d;
      if (state_q == ST_IDLE && dbg_req_i) begin
        cap_we_q    <= dbg_we_i;
        cap_addr_q  <= dbg_addr_i;
        cap_wdata_q <= dbg_wdata_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (we_i && waddr_i != '0) begin
      regs_q[waddr_i] <= wdata_i;
    end else if (dbg_commit_wr && cap_addr_q != '0) begin
      regs_q[cap_addr_q] <= cap_wdata_q;
    end
  end

  assign dbg_busy_o  = (state_q != ST_IDLE);
  assign dbg_ack_o   = (state_q == ST_ACK);
  assign dbg_rdata_o = dbg_rdata_q;

endmodule

// File: tb/tb_gpr_file.sv
// Directed bench for gpr_file: inputs change 1ns after a rising edge, outputs
// are checked mid-cycle against hand-computed values.
module tb_gpr_file;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          we_i;
  logic [AW-1:0] waddr_i;
  logic [DW-1:0] wdata_i;
  logic [AW-1:0] raddr1_i;
  logic [DW-1:0] rdata1_o;
  logic [AW-1:0] raddr2_i;
  logic [DW-1:0] rdata2_o;
  logic          dbg_req_i;
  logic          dbg_we_i;
  logic [AW-1:0] dbg_addr_i;
  logic [DW-1:0] dbg_wdata_i;
  logic          dbg_busy_o;
  logic          dbg_ack_o;
  logic [DW-1:0] dbg_rdata_o;

  int total = 0;
  int bad   = 0;
  int ack_cnt;

  gpr_file #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .raddr1_i(raddr1_i), .rdata1_o(rdata1_o),
    .raddr2_i(raddr2_i), .rdata2_o(rdata2_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_busy_o(dbg_busy_o), .dbg_ack_o(dbg_ack_o),
    .dbg_rdata_o(dbg_rdata_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; we_i = 0; waddr_i = 0; wdata_i = 0; raddr1_i = 0; raddr2_i = 0;
    dbg_req_i = 0; dbg_we_i = 0; dbg_addr_i = 0; dbg_wdata_i = 0;
    tick(); tick();
    check_eq("rst_busy", {31'd0, dbg_busy_o}, 32'd0);
    check_eq("rst_ack", {31'd0, dbg_ack_o}, 32'd0);
    check_eq("rst_drdata", dbg_rdata_o, 32'd0);
    rst = 1'b0;
    tick();

    // all registers zero after reset
    for (int i = 1; i < 32; i++) begin
      raddr1_i = AW'(i); raddr2_i = AW'(i);
      #1;
      check_eq("rst_rd1", rdata1_o, 32'd0);
      check_eq("rst_rd2", rdata2_o, 32'd0);
    end

    // plain write then read
    we_i = 1; waddr_i = 5; wdata_i = 32'hDEADBEEF;
    tick();
    we_i = 0; raddr1_i = 5; #1;
    check_eq("wr_x5", rdata1_o, 32'hDEADBEEF);

    // same-cycle bypass on both ports
    we_i = 1; waddr_i = 7; wdata_i = 32'h12345678; raddr1_i = 7; raddr2_i = 7; #1;
    check_eq("byp_rd1", rdata1_o, 32'h12345678);
    check_eq("byp_rd2", rdata2_o, 32'h12345678);
    tick();
    we_i = 1; waddr_i = 0; wdata_i = 32'hFFFFFFFF; raddr1_i = 0; #1;
    check_eq("x0_byp", rdata1_o, 32'd0);
    tick();
    we_i = 0; #1;
    check_eq("x0_after", rdata1_o, 32'd0);
    check_eq("x7_reg", rdata2_o, 32'h12345678);

    // debug write x10
    dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 10; dbg_wdata_i = 32'hA5A5A5A5;
    tick();
    dbg_req_i = 0; raddr1_i = 10; #1;
    check_eq("dw_busy0", {31'd0, dbg_busy_o}, 32'd1);
    check_eq("dw_ack0", {31'd0, dbg_ack_o}, 32'd0);
    check_eq("dw_commit_byp", rdata1_o, 32'hA5A5A5A5);
    tick();
    check_eq("dw_busy1", {31'd0, dbg_busy_o}, 32'd1);
    check_eq("dw_ack1", {31'd0, dbg_ack_o}, 32'd1);
    tick();
    check_eq("dw_busy2", {31'd0, dbg_busy_o}, 32'd0);
    check_eq("dw_ack2", {31'd0, dbg_ack_o}, 32'd0);
    check_eq("dw_x10", rdata1_o, 32'hA5A5A5A5);

    // debug read x10
    dbg_req_i = 1; dbg_we_i = 0; dbg_addr_i = 10;
    tick();
    dbg_req_i = 0;
    tick();
    check_eq("dr_ack", {31'd0, dbg_ack_o}, 32'd1);
    check_eq("dr_data", dbg_rdata_o, 32'hA5A5A5A5);
    tick();
    check_eq("dr_ack_end", {31'd0, dbg_ack_o}, 32'd0);

    // debug write stalled by four pipeline writes to x4
    dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 3; dbg_wdata_i = 32'h1;
    we_i = 1; waddr_i = 4; wdata_i = 32'd100; raddr1_i = 3; raddr2_i = 4;
    tick();
    dbg_req_i = 0;
    for (int k = 1; k <= 3; k++) begin
      wdata_i = 32'(100 + k); #1;
      check_eq("stall_busy", {31'd0, dbg_busy_o}, 32'd1);
      check_eq("stall_ack", {31'd0, dbg_ack_o}, 32'd0);
      check_eq("stall_x3", rdata1_o, 32'd0);
      tick();
    end
    we_i = 0; #1;
    check_eq("stall_end_busy", {31'd0, dbg_busy_o}, 32'd1);
    check_eq("stall_end_ack", {31'd0, dbg_ack_o}, 32'd0);
    check_eq("stall_commit_byp", rdata1_o, 32'h1);
    tick();
    check_eq("stall_ack1", {31'd0, dbg_ack_o}, 32'd1);
    check_eq("stall_x3_reg", rdata1_o, 32'h1);
    check_eq("stall_x4", rdata2_o, 32'd103);
    tick();
    check_eq("stall_idle", {31'd0, dbg_busy_o}, 32'd0);

    // debug read x9 racing a pipeline write, plus an ignored request in PEND
    dbg_req_i = 1; dbg_we_i = 0; dbg_addr_i = 9;
    tick();
    dbg_addr_i = 1;
    we_i = 1; waddr_i = 9; wdata_i = 32'h55;
    tick();
    dbg_req_i = 0; we_i = 0;
    check_eq("race_ack", {31'd0, dbg_ack_o}, 32'd1);
    check_eq("race_data", dbg_rdata_o, 32'h55);
    ack_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (dbg_ack_o) ack_cnt++;
    end
    check_eq("race_extra_acks", 32'(ack_cnt), 32'd0);
    check_eq("race_hold", dbg_rdata_o, 32'h55);

    // reset while a debug write to x2 is pending
    dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 2; dbg_wdata_i = 32'hCAFEF00D;
    we_i = 1; waddr_i = 6; wdata_i = 32'h66; raddr1_i = 2; raddr2_i = 5;
    tick();
    dbg_req_i = 0;
    check_eq("rstp_busy", {31'd0, dbg_busy_o}, 32'd1);
    rst = 1; #1;
    check_eq("rstp_busy0", {31'd0, dbg_busy_o}, 32'd0);
    we_i = 0;
    tick(); tick();
    rst = 0;
    ack_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (dbg_ack_o) ack_cnt++;
    end
    check_eq("rstp_acks", 32'(ack_cnt), 32'd0);
    check_eq("rstp_x2", rdata1_o, 32'd0);
    check_eq("rstp_x5", rdata2_o, 32'd0);
    check_eq("rstp_drdata", dbg_rdata_o, 32'd0);

    dbg_req_i = 1;
    tick();
    dbg_req_i = 0;
    tick();
    check_eq("post_ack", {31'd0, dbg_ack_o}, 32'd1);
    tick();
    check_eq("post_x2", rdata1_o, 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
